fifo_burst_reader: RTL

- Read-side drain engine for the team's FIFOs. Runs in the read clock domain.
- On a start command it pops exactly burst_len words from a FIFO read port whose data appears one cycle after a pop. Empty blocks further pops.
- Delivers the words on a valid/ready stream through a 2-entry skid buffer, so downstream backpressure never drops a word that is already in flight.
- Pairs with the FIFO write side as the consumer of its data_out/empty/rd_en port.

---
 rtl/fifo_burst_reader.sv | 80 ++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of words from a FIFO read port and streams them out through a 2-entry skid buffer
// Ports:
//   rclk, reset (sync, active-low)
//   start, burst_len            burst request, taken only when idle
//   fifo_empty, fifo_rd_en,     FIFO read port; fifo_data is valid the cycle after a pop
//   fifo_data
//   m_data, m_valid, m_ready    output stream
//   busy, done, word_cnt        status: reading/draining, end-of-burst pulse, words delivered
module fifo_burst_reader #(
    parameter int WIDTH = 4,
    parameter int LENW  = 5
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             start,
    input  logic [LENW-1:0]  burst_len,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [LENW-1:0]  word_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]       state, state_nx;
    logic [LENW-1:0]  len, issued;
    logic             inflight, pop, take;
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       buf_count;
    logic [2:0]       occ;
    assign m_valid = buf_count != 2'd0;
    assign m_data  = mem[rd_ptr];
    assign pop     = m_valid & m_ready;
    assign take    = (state == IDLE) & start;
    // words already committed to the buffer once this cycle's transfer leaves
    assign occ        = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = reset & (state == READ) & ~fifo_empty & (issued < len) & (occ < 3'd2);
    assign busy       = (state == READ) | (state == DRAIN);
    assign done       = state == DONE;
    always_comb begin
        state_nx = state == IDLE  ? (start ? (burst_len != '0 ? READ : DONE) : IDLE)
                 : state == READ  ? ((fifo_rd_en && LENW'(issued + 1'b1) == len) ? DRAIN : READ)
                 : state == DRAIN ? ((word_cnt == len && !inflight && buf_count == 2'd0) ? DONE : DRAIN)
                 : IDLE;
    end
    always_ff @(posedge rclk) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= '0;
            issued    <= '0;
            word_cnt  <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            state    <= state_nx;
            inflight <= fifo_rd_en;
            len      <= take ? burst_len : len;
            issued   <= take ? '0 : fifo_rd_en ? LENW'(issued + 1'b1) : issued;
            word_cnt <= take ? '0 : pop ? LENW'(word_cnt + 1'b1) : word_cnt;
            if (inflight) begin
                mem[wr_ptr] <= fifo_data;
                wr_ptr      <= ~wr_ptr;
            end
            rd_ptr    <= pop ? ~rd_ptr : rd_ptr;
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
            assert (buf_count <= 2'd2);
        end
    end
endmodule
